// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: IDLE -> RUN -> HALTED, with halt > branch > increment priority.
// Optional macro PROG_SEQ_EN rotates through three program start addresses on each restart.
module fetch_ctrl #(
  parameter int PC_W        = 10,
  parameter int PROG1_START = 0,
  parameter int PROG2_START = 100,
  parameter int PROG3_START = 200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_en,
  input  logic            branch_rel,
  input  logic [PC_W-1:0] branch_tgt,
  input  logic            halt,
  output logic [PC_W-1:0] pc_out,
  output logic            fetch_valid,
  output logic            done,
  output logic [1:0]      prog_id
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic            en;
    logic            rel;
    logic [PC_W-1:0] tgt;
  } br_req_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      prog_q, prog_d, prog_nxt;
  br_req_t         br;
  logic [PC_W-1:0] rel_off, br_pc;

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] id);
    case (id)
      2'd1:    return PC_W'(PROG2_START);
      2'd2:    return PC_W'(PROG3_START);
      default: return PC_W'(PROG1_START);
    endcase
  endfunction

`ifdef PROG_SEQ_EN
  assign prog_nxt = (prog_q == 2'd2) ? 2'd0 : prog_q + 2'd1;
`else
  assign prog_nxt = 2'd0;
`endif

  assign br.en  = branch_en;
  assign br.rel = branch_rel;
  assign br.tgt = branch_tgt;

  // Relative offset is the low byte sign-extended; the add wraps naturally at PC_W.
  assign rel_off = PC_W'($signed(br.tgt[7:0]));
  assign br_pc   = br.rel ? pc_q + rel_off : br.tgt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(PROG1_START);
      prog_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prog_q  <= prog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    prog_d  = prog_q;
    case (state_q)
      IDLE: begin
        pc_d = start_addr(prog_q);
        if (start) state_d = RUN;
      end
      RUN: begin
        // stall freezes everything; halt outranks any branch in the same cycle
        if (!stall) begin
          if (halt)       state_d = HALTED;
          else if (br.en) pc_d    = br_pc;
          else            pc_d    = pc_q + PC_W'(1);
        end
      end
      HALTED: begin
        if (start) begin
          state_d = RUN;
          prog_d  = prog_nxt;
          pc_d    = start_addr(prog_nxt);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_out      = pc_q;
    prog_id     = prog_q;
    fetch_valid = (state_q == RUN);
    done        = (state_q == HALTED);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, increment/wrap, branches, stall, halt, restart, async reset.
module tb_fetch_ctrl;
  localparam int PC_W = 10;

  logic            clk, reset, start, stall, branch_en, branch_rel, halt;
  logic [PC_W-1:0] branch_tgt, pc_out;
  logic            fetch_valid, done;
  logic [1:0]      prog_id;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.PC_W(PC_W), .PROG1_START(0), .PROG2_START(100), .PROG3_START(200)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_rel(branch_rel), .branch_tgt(branch_tgt),
    .halt(halt), .pc_out(pc_out), .fetch_valid(fetch_valid), .done(done),
    .prog_id(prog_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic rel, input int unsigned tgt);
    branch_en  = 1'b1;
    branch_rel = rel;
    branch_tgt = PC_W'(tgt);
    cyc();
    branch_en  = 1'b0;
    branch_rel = 1'b0;
  endtask

  int unsigned exp_pc[3];
  int unsigned exp_id[3];

  initial begin
`ifdef PROG_SEQ_EN
    exp_pc = '{100, 200, 0};
    exp_id = '{1, 2, 0};
`else
    exp_pc = '{0, 0, 0};
    exp_id = '{0, 0, 0};
`endif
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    branch_rel = 1'b0; branch_tgt = '0; halt = 1'b0;
    #2;
    chk("rst_pc", pc_out, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_id", prog_id, 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("idle_fv", fetch_valid, 0);
    chk("idle_pc", pc_out, 0);
    cyc();
    chk("idle_hold_fv", fetch_valid, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_fv", fetch_valid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_out, i);
      if (i < 3) cyc();
    end

    do_branch(1'b0, 50);
    chk("abs50", pc_out, 50);
    do_branch(1'b1, 8'hFE);
    chk("rel_m2", pc_out, 48);
    do_branch(1'b0, 300);
    chk("abs300", pc_out, 300);
    do_branch(1'b0, 1023);
    chk("abs1023", pc_out, 1023);
    cyc();
    chk("wrap0", pc_out, 0);
    do_branch(1'b1, 8'h03);
    chk("rel_p3", pc_out, 3);
    do_branch(1'b1, 8'h00);
    chk("rel_self", pc_out, 3);
    // relative branch backwards across zero wraps modulo 2^PC_W
    do_branch(1'b1, 8'hFB);
    chk("rel_wrap", pc_out, 1022);

    do_branch(1'b0, 7);
    chk("abs7", pc_out, 7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      halt      = (i == 1);
      branch_en = (i == 2);
      branch_tgt = PC_W'(555);
      cyc();
      chk("stall_pc", pc_out, 7);
      chk("stall_fv", fetch_valid, 1);
    end
    stall = 1'b0; halt = 1'b0; branch_en = 1'b0;
    cyc();
    chk("post_stall", pc_out, 8);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_run_pc", pc_out, 9);
    chk("start_run_fv", fetch_valid, 1);

    do_branch(1'b0, 20);
    halt = 1'b1; branch_en = 1'b1; branch_tgt = PC_W'(99);
    cyc();
    halt = 1'b0; branch_en = 1'b0;
    chk("halt_pc", pc_out, 20);
    chk("halt_done", done, 1);
    chk("halt_fv", fetch_valid, 0);
    halt = 1'b1; branch_en = 1'b1; stall = 1'b1;
    cyc();
    halt = 1'b0; branch_en = 1'b0; stall = 1'b0;
    chk("halted_pc", pc_out, 20);
    chk("halted_done", done, 1);

    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("reload_pc", pc_out, exp_pc[k]);
      chk("reload_id", prog_id, exp_id[k]);
      chk("reload_done", done, 0);
      chk("reload_fv", fetch_valid, 1);
      cyc();
      chk("reload_inc", pc_out, exp_pc[k] + 1);
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      chk("rehalt_done", done, 1);
    end

    start = 1'b1;
    cyc();
    start = 1'b0;
    do_branch(1'b0, 37);
    chk("pc37", pc_out, 37);
    #3;
    reset = 1'b0;
    #1;
    chk("async_pc", pc_out, 0);
    chk("async_done", done, 0);
    chk("async_fv", fetch_valid, 0);
    chk("async_id", prog_id, 0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    chk("post_rst_idle", fetch_valid, 0);
    chk("post_rst_pc", pc_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
